pdl_stack_ctl: RTL and testbench
================================

Name: pdl_stack_ctl

Overview:
- Control stage directly upstream of the 1kx32 PDL (pushdown list) RAM.
- Owns the PDL pointer and PDL index registers and accepts stack and indexed commands from the microsequencer.
- Drives the RAM's address, data and read/write enables, then returns read data with fixed latency.
- Detects stack overflow and underflow against a programmable limit.

Parameters:
- AW, 10, PDL address width; must match the RAM depth of 1024 words.
- DW, 32, data width.
- PDL_LIMIT, 1023, highest legal pointer value for a push.

Ports:
- clk  in  1  single clock; drives this block and the RAM port.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  block accepts a command this cycle.
- req_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 READ_TOP, 4 READ_IDX, 5 WRITE_IDX, 6 LOAD_PTR, 7 LOAD_IDX.
- req_data  in  DW  write data, or new pointer/index in bits [AW-1:0].
- rsp_valid  out  1  read response valid, one-cycle pulse.
- rsp_data  out  DW  read data.
- rsp_err  out  1  qualifies rsp_valid: the op was refused (underflow).
- ram_addr  out  AW  RAM address.
- ram_data  out  DW  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rden  out  1  RAM read enable.
- ram_q  in  DW  RAM read data, registered, valid the cycle after ram_rden.
- pdl_ptr  out  AW  current pointer.
- pdl_idx  out  AW  current index.
- ovf_err  out  1  sticky overflow flag.
- unf_err  out  1  sticky underflow flag.
- clr_err  in  1  clears ovf_err and unf_err.

Behaviour:
- Reset (async): state IDLE; pdl_ptr=0, pdl_idx=0; ram_addr/ram_data=0; ram_wren=ram_rden=0; rsp_valid=rsp_err=0; rsp_data=0; ovf_err=unf_err=0.
- Reset asserted mid-operation aborts the op: no response is issued and no RAM strobe is emitted after reset is released.
- FSM states:
  - IDLE: req_ready=1.
  - ISSUE: one cycle; RAM controls are driven from registers.
  - WAIT: RAM data returning.
- Handshake: a command is accepted when req_valid&&req_ready in cycle N. req_ready=0 in ISSUE and WAIT.
- NOP: accepted, no effect, stays in IDLE.
- LOAD_PTR / LOAD_IDX: register updated at the end of N; stays in IDLE; no RAM access.
- PUSH (pre-increment):
  - Legal push (ptr!=PDL_LIMIT): ptr<=ptr+1 at end of N. In N+1 (ISSUE): ram_addr=new ptr, ram_data=req_data, ram_wren=1. Return to IDLE at N+2.
  - ptr==PDL_LIMIT: refused. No write, ptr unchanged, ovf_err<=1, goes directly to IDLE.
- WRITE_IDX: ISSUE cycle with ram_addr=idx and ram_wren=1; ptr and idx unchanged.
- Reads (POP, READ_TOP, READ_IDX):
  - N+1 (ISSUE): ram_rden=1; ram_addr=ptr (POP, READ_TOP) or idx (READ_IDX).
  - N+2 (WAIT): rsp_valid=1, rsp_data=ram_q, rsp_err=0; back to IDLE at N+3.
  - POP post-decrements: ptr<=ptr-1 at end of N+1.
- POP with ptr==0 is refused:
  - no ram_rden and ptr unchanged; unf_err<=1.
  - ISSUE and WAIT timing is still traversed; at N+2 rsp_valid=1, rsp_err=1, rsp_data=0.
  - Fixed latency of 2 is preserved.
- Throughput:
  - Read ops: one per 3 cycles.
  - Write ops (PUSH, WRITE_IDX): one per 2 cycles.
  - Loads and NOP: one per cycle.
- Strobes: ram_wren and ram_rden are never both 1 and are only high in ISSUE.
- Width and wrap rules:
  - ptr/idx arithmetic is modulo 2^AW.
  - The only guards are PDL_LIMIT on push and 0 on pop.
  - LOAD_PTR may set any value, including above PDL_LIMIT; a later push is then checked with equality only and wraps modulo 2^AW.
- Sticky flags: clr_err clears ovf_err and unf_err. Same-cycle error set wins over clr_err.

Test Plan:
- Reset, then PUSH 0x11111111, PUSH 0x22222222 -> writes at addr 1 then 2, ptr=2. POP -> rsp_data=0x22222222 exactly 2 cycles after accept, ptr=1.
- LOAD_IDX 0x155, WRITE_IDX 0xDEADBEEF, READ_IDX -> ram_addr=0x155 on both accesses, rsp_data=0xDEADBEEF; ptr unchanged.
- POP at ptr=0 -> no ram_rden, rsp_valid with rsp_err=1 and rsp_data=0 at N+2, unf_err=1. Pulse clr_err -> unf_err=0.
- LOAD_PTR 1023, PUSH -> no ram_wren, ptr=1023, ovf_err=1. LOAD_PTR 1022, PUSH -> write at 1023.
- Back-to-back: hold req_valid with PUSH, READ_TOP, LOAD_PTR 5 -> req_ready low in ISSUE and WAIT. Accept spacing is 2, 3, 1 cycles. READ_TOP returns the pushed data.
- Assert reset during the WAIT of a POP -> no rsp_valid, all outputs 0 asynchronously. Next PUSH after release writes addr 1.

Source files
------------

// File: rtl/pdl_stack_ctl.sv
// Control stage in front of the 1kx32 PDL RAM: owns the stack pointer and index registers,
// sequences push/pop/indexed accesses and returns read data with a fixed two-cycle latency.
module pdl_stack_ctl #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 32,
  parameter int unsigned PDL_LIMIT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic          ram_rden,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] pdl_ptr,
  output logic [AW-1:0] pdl_idx,
  output logic          ovf_err,
  output logic          unf_err,
  input  logic          clr_err
);

  typedef enum logic [2:0] {
    OpNop      = 3'd0,
    OpPush     = 3'd1,
    OpPop      = 3'd2,
    OpReadTop  = 3'd3,
    OpReadIdx  = 3'd4,
    OpWriteIdx = 3'd5,
    OpLoadPtr  = 3'd6,
    OpLoadIdx  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  localparam logic [AW-1:0] Limit = AW'(PDL_LIMIT);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wren_q, wren_d;
  logic          rden_q, rden_d;
  logic          pop_q, pop_d;
  logic          read_q, read_d;
  logic          refuse_q, refuse_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  op_e           op;

  assign op = op_e'(req_op);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    pop_d    = pop_q;
    read_d   = read_q;
    refuse_d = refuse_q;
    // Error sets below override the clear.
    ovf_d    = ovf_q & ~clr_err;
    unf_d    = unf_q & ~clr_err;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          pop_d    = 1'b0;
          read_d   = 1'b0;
          refuse_d = 1'b0;
          unique case (op)
            OpPush: begin
              if (ptr_q == Limit) begin
                ovf_d = 1'b1;
              end else begin
                ptr_d   = ptr_q + AW'(1);
                addr_d  = ptr_q + AW'(1);
                wdata_d = req_data;
                wren_d  = 1'b1;
                state_d = StIssue;
              end
            end
            OpWriteIdx: begin
              addr_d  = idx_q;
              wdata_d = req_data;
              wren_d  = 1'b1;
              state_d = StIssue;
            end
            OpPop, OpReadTop, OpReadIdx: begin
              addr_d  = (op == OpReadIdx) ? idx_q : ptr_q;
              read_d  = 1'b1;
              state_d = StIssue;
              // A refused pop still walks ISSUE/WAIT so the response latency never changes.
              if (op == OpPop && ptr_q == '0) begin
                refuse_d = 1'b1;
                unf_d    = 1'b1;
              end else begin
                rden_d = 1'b1;
                pop_d  = (op == OpPop);
              end
            end
            OpLoadPtr: ptr_d = req_data[AW-1:0];
            OpLoadIdx: idx_d = req_data[AW-1:0];
            OpNop:     ;
            default:   ;
          endcase
        end
      end
      StIssue: begin
        if (pop_q) begin
          ptr_d = ptr_q - AW'(1);
        end
        state_d = read_q ? StWait : StIdle;
      end
      StWait:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      pop_q    <= 1'b0;
      read_q   <= 1'b0;
      refuse_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      pop_q    <= pop_d;
      read_q   <= read_d;
      refuse_q <= refuse_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Strobe registers are only loaded on the IDLE->ISSUE transition, so they are high for ISSUE only.
  assign req_ready = (state_q == StIdle);
  assign ram_addr  = addr_q;
  assign ram_data  = wdata_q;
  assign ram_wren  = wren_q;
  assign ram_rden  = rden_q;
  assign rsp_valid = (state_q == StWait);
  assign rsp_err   = (state_q == StWait) & refuse_q;
  assign rsp_data  = (state_q == StWait && !refuse_q) ? ram_q : '0;
  assign pdl_ptr   = ptr_q;
  assign pdl_idx   = idx_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: tb/tb_pdl_stack_ctl.sv
// Directed bench for pdl_stack_ctl with a behavioural 1kx32 RAM (registered read) on the RAM port.
module tb_pdl_stack_ctl;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_PUSH      = 3'd1;
  localparam logic [2:0] OP_POP       = 3'd2;
  localparam logic [2:0] OP_READ_TOP  = 3'd3;
  localparam logic [2:0] OP_READ_IDX  = 3'd4;
  localparam logic [2:0] OP_WRITE_IDX = 3'd5;
  localparam logic [2:0] OP_LOAD_PTR  = 3'd6;
  localparam logic [2:0] OP_LOAD_IDX  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic        ram_rden;
  logic [31:0] ram_q;
  logic [9:0]  pdl_ptr;
  logic [9:0]  pdl_idx;
  logic        ovf_err;
  logic        unf_err;
  logic        clr_err;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] mem [1024];

  pdl_stack_ctl #(
    .AW       (10),
    .DW       (32),
    .PDL_LIMIT(1023)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_rden (ram_rden),
    .ram_q    (ram_q),
    .pdl_ptr  (pdl_ptr),
    .pdl_idx  (pdl_idx),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  // Called at a negedge in IDLE; returns at the next negedge (cycle N+1) with the request dropped.
  task automatic send(input logic [2:0] op, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_data  = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_data  = '0;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (pdl_ptr !== 10'd0) $display("FAIL rst_ptr: got %0h want 0", pdl_ptr); else n_pass++;
    n_total++; if (pdl_idx !== 10'd0) $display("FAIL rst_idx: got %0h want 0", pdl_idx); else n_pass++;
    n_total++; if ({ram_wren, ram_rden} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {ram_wren, ram_rden}); else n_pass++;
    n_total++; if ({ram_addr, ram_data} !== 42'd0) $display("FAIL rst_ram_bus: got %0h want 0", {ram_addr, ram_data}); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL rst_rsp: got %b want 00", {rsp_valid, rsp_err}); else n_pass++;
    n_total++; if (rsp_data !== 32'd0) $display("FAIL rst_rsp_data: got %0h want 0", rsp_data); else n_pass++;
    n_total++; if ({ovf_err, unf_err} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {ovf_err, unf_err}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_push_pop();
    send(OP_PUSH, 32'h1111_1111);
    n_total++; if (ram_wren !== 1'b1 || ram_rden !== 1'b0) $display("FAIL push1_strobe: got w%b r%b want w1 r0", ram_wren, ram_rden); else n_pass++;
    n_total++; if (ram_addr !== 10'd1) $display("FAIL push1_addr: got %0h want 1", ram_addr); else n_pass++;
    n_total++; if (ram_data !== 32'h1111_1111) $display("FAIL push1_data: got %0h want 11111111", ram_data); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL push1_ready_issue: got %b want 0", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (ram_wren !== 1'b0 || req_ready !== 1'b1) $display("FAIL push1_done: got w%b rdy%b want w0 rdy1", ram_wren, req_ready); else n_pass++;
    send(OP_PUSH, 32'h2222_2222);
    n_total++; if (ram_wren !== 1'b1 || ram_addr !== 10'd2) $display("FAIL push2_write: got w%b a%0h want w1 a2", ram_wren, ram_addr); else n_pass++;
    @(negedge clk);
    n_total++; if (pdl_ptr !== 10'd2) $display("FAIL push2_ptr: got %0h want 2", pdl_ptr); else n_pass++;
    send(OP_POP, 32'h0);
    n_total++; if (ram_rden !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== 10'd2) $display("FAIL pop_issue: got r%b w%b a%0h want r1 w0 a2", ram_rden, ram_wren, ram_addr); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL pop_early_rsp: got %b want 0", rsp_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL pop_rsp: got v%b e%b want v1 e0", rsp_valid, rsp_err); else n_pass++;
    n_total++; if (rsp_data !== 32'h2222_2222) $display("FAIL pop_data: got %0h want 22222222", rsp_data); else n_pass++;
    n_total++; if (pdl_ptr !== 10'd1) $display("FAIL pop_ptr: got %0h want 1", pdl_ptr); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL pop_done: got v%b rdy%b want v0 rdy1", rsp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_indexed();
    send(OP_LOAD_IDX, 32'h0000_0155);
    n_total++; if (pdl_idx !== 10'h155) $display("FAIL ldidx_val: got %0h want 155", pdl_idx); else n_pass++;
    n_total++; if (req_ready !== 1'b1 || ram_wren !== 1'b0 || ram_rden !== 1'b0) $display("FAIL ldidx_noaccess: got rdy%b w%b r%b want 1 0 0", req_ready, ram_wren, ram_rden); else n_pass++;
    send(OP_WRITE_IDX, 32'hDEAD_BEEF);
    n_total++; if (ram_wren !== 1'b1 || ram_addr !== 10'h155 || ram_data !== 32'hDEAD_BEEF) $display("FAIL wridx: got w%b a%0h d%0h want w1 a155 dDEADBEEF", ram_wren, ram_addr, ram_data); else n_pass++;
    @(negedge clk);
    send(OP_READ_IDX, 32'h0);
    n_total++; if (ram_rden !== 1'b1 || ram_addr !== 10'h155) $display("FAIL rdidx_issue: got r%b a%0h want r1 a155", ram_rden, ram_addr); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) $display("FAIL rdidx_rsp: got v%b d%0h want v1 dDEADBEEF", rsp_valid, rsp_data); else n_pass++;
    n_total++; if (pdl_ptr !== 10'd1 || pdl_idx !== 10'h155) $display("FAIL rdidx_regs: got p%0h i%0h want p1 i155", pdl_ptr, pdl_idx); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_underflow();
    send(OP_LOAD_PTR, 32'h0);
    n_total++; if (pdl_ptr !== 10'd0) $display("FAIL unf_ldptr: got %0h want 0", pdl_ptr); else n_pass++;
    send(OP_POP, 32'h0);
    n_total++; if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || req_ready !== 1'b0) $display("FAIL unf_issue: got r%b w%b rdy%b want 0 0 0", ram_rden, ram_wren, req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) $display("FAIL unf_rsp: got v%b e%b want v1 e1", rsp_valid, rsp_err); else n_pass++;
    n_total++; if (rsp_data !== 32'd0) $display("FAIL unf_rsp_data: got %0h want 0", rsp_data); else n_pass++;
    n_total++; if (unf_err !== 1'b1 || pdl_ptr !== 10'd0) $display("FAIL unf_flag: got u%b p%0h want u1 p0", unf_err, pdl_ptr); else n_pass++;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_total++; if (unf_err !== 1'b0) $display("FAIL unf_clear: got %b want 0", unf_err); else n_pass++;
  endtask

  task automatic test_overflow();
    send(OP_LOAD_PTR, 32'h0000_03FF);
    clr_err = 1'b1;
    send(OP_PUSH, 32'hCAFE_F00D);
    clr_err = 1'b0;
    n_total++; if (ram_wren !== 1'b0 || pdl_ptr !== 10'h3FF) $display("FAIL ovf_refuse: got w%b p%0h want w0 p3ff", ram_wren, pdl_ptr); else n_pass++;
    n_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_set_beats_clr: got %b want 1", ovf_err); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL ovf_idle: got %b want 1", req_ready); else n_pass++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_total++; if (ovf_err !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf_err); else n_pass++;
    send(OP_LOAD_PTR, 32'h0000_03FE);
    send(OP_PUSH, 32'h0BAD_F00D);
    n_total++; if (ram_wren !== 1'b1 || ram_addr !== 10'h3FF || pdl_ptr !== 10'h3FF) $display("FAIL ovf_lastpush: got w%b a%0h p%0h want w1 a3ff p3ff", ram_wren, ram_addr, pdl_ptr); else n_pass++;
    @(negedge clk);
    n_total++; if (ovf_err !== 1'b0) $display("FAIL ovf_lastpush_flag: got %b want 0", ovf_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4];
    logic [31:0] dat [4];
    int          t [4];
    int          cyc;
    int          guard;
    int          busy;
    logic        rd_seen;
    logic [31:0] rd;
    ops[0] = OP_PUSH;     dat[0] = 32'hA5A5_A5A5;
    ops[1] = OP_READ_TOP; dat[1] = 32'h0;
    ops[2] = OP_LOAD_PTR; dat[2] = 32'h0000_0005;
    ops[3] = OP_LOAD_IDX; dat[3] = 32'h0000_0007;
    send(OP_LOAD_PTR, 32'h0000_0003);
    cyc     = 0;
    busy    = 0;
    rd_seen = 1'b0;
    rd      = '0;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_op   = ops[k];
      req_data = dat[k];
      guard    = 0;
      while (!req_ready && guard < 8) begin
        busy++;
        if (rsp_valid) begin
          rd_seen = 1'b1;
          rd      = rsp_data;
        end
        @(negedge clk);
        cyc++;
        guard++;
      end
      t[k] = cyc;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_data  = '0;
    n_total++; if (t[1] - t[0] != 2) $display("FAIL b2b_push_spacing: got %0d want 2", t[1] - t[0]); else n_pass++;
    n_total++; if (t[2] - t[1] != 3) $display("FAIL b2b_read_spacing: got %0d want 3", t[2] - t[1]); else n_pass++;
    n_total++; if (t[3] - t[2] != 1) $display("FAIL b2b_load_spacing: got %0d want 1", t[3] - t[2]); else n_pass++;
    n_total++; if (busy != 3) $display("FAIL b2b_busy_cycles: got %0d want 3", busy); else n_pass++;
    n_total++; if (rd_seen !== 1'b1 || rd !== 32'hA5A5_A5A5) $display("FAIL b2b_readtop: got seen%b d%0h want seen1 dA5A5A5A5", rd_seen, rd); else n_pass++;
    n_total++; if (pdl_ptr !== 10'd5 || pdl_idx !== 10'd7) $display("FAIL b2b_regs: got p%0h i%0h want p5 i7", pdl_ptr, pdl_idx); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic bad;
    send(OP_LOAD_PTR, 32'h0);
    send(OP_PUSH, 32'h4444_4444);
    @(negedge clk);
    send(OP_POP, 32'h0);
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL rstmid_in_wait: got %b want 1", rsp_valid); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) $display("FAIL rstmid_rsp: got v%b d%0h e%b want 0 0 0", rsp_valid, rsp_data, rsp_err); else n_pass++;
    n_total++; if (pdl_ptr !== 10'd0 || ram_addr !== 10'd0 || ram_data !== 32'd0) $display("FAIL rstmid_regs: got p%0h a%0h d%0h want 0 0 0", pdl_ptr, ram_addr, ram_data); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bad   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bad = bad | rsp_valid | ram_wren | ram_rden | ~req_ready;
    end
    n_total++; if (bad !== 1'b0) $display("FAIL rstmid_aborted: got activity %b want 0", bad); else n_pass++;
    send(OP_PUSH, 32'h5555_5555);
    n_total++; if (ram_wren !== 1'b1 || ram_addr !== 10'd1 || ram_data !== 32'h5555_5555) $display("FAIL rstmid_push: got w%b a%0h d%0h want w1 a1 d55555555", ram_wren, ram_addr, ram_data); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_indexed();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
